iter_div_unit: RTL
==================

Name: iter_div_unit

Overview:
Parametrised multi-cycle integer divider for the EX stage. It replaces the fixed-width, dual-IP divider pair with a single radix-2 restoring engine. One engine handles signed/unsigned quotient and remainder (div.w, mod.w, div.wu, mod.wu). It uses a valid/ready handshake on both sides, plus a pipeline flush that cancels an in-flight operation.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
flush  in  1  cancel in-flight op, discard result
in_valid  in  1  request valid
in_ready  out  1  unit can accept request this cycle
in_signed  in  1  1 = signed operands, 0 = unsigned
in_rem  in  1  1 = return remainder, 0 = return quotient
in_src1  in  WIDTH  dividend
in_src2  in  WIDTH  divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  quotient or remainder
busy  out  1  state != IDLE

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high. All state updates occur on posedge clk.
- States: IDLE, CALC, DONE. Reset -> IDLE, counter = 0, out_valid = 0, out_result = 0, busy = 0.
- in_ready = ~flush & (IDLE | (DONE & out_ready)). Accept = in_valid & in_ready.
- On accept, latch in_signed and in_rem, then:
  - Latch abs(src1) and abs(src2) into working registers. Use the two's complement magnitude when in_signed and MSB=1. |min| = 2^(WIDTH-1) is represented unsigned.
  - Latch q_neg = signed & (src1[MSB] ^ src2[MSB]) and r_neg = signed & src1[MSB].
  - If src2 == 0, go directly to DONE with quotient = all ones and remainder = src1 unchanged (no sign fixup). Result is visible the cycle after the accept edge.
  - Otherwise go to CALC with counter = WIDTH and partial remainder = 0.
- CALC performs one restoring step per cycle:
  - {rem, dvd} shifted left 1.
  - Trial = rem - divisor (WIDTH+1 bits). If trial is non-negative, rem = trial and quotient bit = 1, else 0.
  - Counter decrements. On the step where the counter reaches 0, the state goes to DONE.
- Entering DONE from CALC registers out_result:
  - Quotient path: negate if q_neg.
  - Remainder path: negate if r_neg.
  - Result is the low WIDTH bits.
- Latency: out_valid rises exactly WIDTH+1 cycles after the accept edge (divisor != 0), or 1 cycle after it (divisor == 0). Latency does not depend on operand values.
- Overflow: signed min / -1 yields quotient = min, remainder = 0. This falls out of the magnitude path; no special case is needed.
- DONE: out_valid = 1 and out_result is held stable until out_ready.
  - If out_ready & ~in_valid, go to IDLE.
  - If out_ready & in_valid, the new request is accepted the same edge (back-to-back, no bubble).
- flush (highest priority, any state): next state IDLE, out_valid = 0, counter = 0, and no request is accepted that cycle. out_result holds its last value.
- reset mid-CALC or mid-DONE behaves identically to flush plus clearing out_result.
- Inputs are sampled only on accept. Changing in_src* during CALC has no effect.

Test Plan:
- WIDTH=32, unsigned, rem=0, src1=100, src2=7 -> out_result=14 exactly 33 cycles after the accept edge. Repeat with rem=1 -> 2.
- Signed, src1=-7 (0xFFFFFFF9), src2=2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Also src1=7, src2=-2 -> quotient -3, remainder 1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 -> 0xFFFFFFFF.
- Divide by zero: src1=0x1234, src2=0 -> quotient 0xFFFFFFFF, remainder 0x1234. out_valid is asserted 1 cycle after accept.
- Flush in cycle 10 of CALC -> out_valid never asserts, busy=0 the next cycle. A new request with 20/3 is then accepted and returns 6 with normal latency.
- Hold out_ready=0 for 5 cycles in DONE -> out_result stable and in_ready=0. Then raise out_ready together with a new in_valid -> back-to-back accept. Re-run all cases with WIDTH=8 (e.g. 200/9 unsigned -> 22, remainder 2, latency 9).

Source files
------------

// File: rtl/iter_div_unit.sv
// ============================================================================
// Module      : iter_div_unit
// Description : Multi-cycle radix-2 restoring integer divider (signed/unsigned,
//               quotient or remainder) with valid/ready handshakes and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic             in_rem,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             sel_rem_q, sel_rem_d;

    logic             w_accept;
    logic             w_div0;
    logic [WIDTH-1:0] w_abs1, w_abs2;
    logic [WIDTH:0]   w_shift, w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_step, w_quo_step;
    logic             w_last;

    assign w_accept = in_valid & in_ready;
    assign w_div0   = (in_src2 == '0);

    // The magnitude of the most negative value is kept as an unsigned 2^(WIDTH-1).
    assign w_abs1 = (in_signed & in_src1[WIDTH-1]) ? -in_src1 : in_src1;
    assign w_abs2 = (in_signed & in_src2[WIDTH-1]) ? -in_src2 : in_src2;

    assign w_shift    = {rem_q, dvd_q[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, dvs_q};
    assign w_qbit     = ~w_trial[WIDTH];
    assign w_rem_step = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_step = {dvd_q[WIDTH-2:0], w_qbit};
    assign w_last     = (cnt_q == CNT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) state_d = w_div0 ? S_DONE : S_CALC;
                end
                S_CALC: begin
                    if (w_last) state_d = S_DONE;
                end
                S_DONE: begin
                    if (w_accept)       state_d = w_div0 ? S_DONE : S_CALC;
                    else if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_ready  = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    assign out_result = res_q;

    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        sel_rem_d = sel_rem_q;
        if (flush) begin
            cnt_d = '0;
        end else if (w_accept) begin
            cnt_d     = w_div0 ? '0 : CNT_W'(WIDTH);
            rem_d     = '0;
            dvd_d     = w_abs1;
            dvs_d     = w_abs2;
            q_neg_d   = in_signed & (in_src1[WIDTH-1] ^ in_src2[WIDTH-1]);
            r_neg_d   = in_signed & in_src1[WIDTH-1];
            sel_rem_d = in_rem;
            if (w_div0) res_d = in_rem ? in_src1 : '1;
        end else if (state_q == S_CALC) begin
            rem_d = w_rem_step;
            dvd_d = w_quo_step;
            cnt_d = cnt_q - CNT_W'(1);
            if (w_last) begin
                if (sel_rem_q) res_d = r_neg_q ? -w_rem_step : w_rem_step;
                else           res_d = q_neg_q ? -w_quo_step : w_quo_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            res_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            sel_rem_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            res_q     <= res_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            sel_rem_q <= sel_rem_d;
        end
    end

endmodule

`default_nettype wire
